dlsc_axi_router_cmdq: RTL and testbench



---
 rtl/dlsc_axi_router_cmdq.sv | 207 ++++++++++++++++++++
 tb/tb_dlsc_axi_router_cmdq.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlsc_axi_router_cmdq.sv
// AXI router command stage: per-input command queues, address decode, round-robin
// arbitration and per-output outstanding limits. Optional QoS arbitration: DLSC_AXI_ROUTER_CMDQ_QOS_EN.
`timescale 1ns/1ps
module dlsc_axi_router_cmdq #(
    parameter int                      ADDR     = 32,
    parameter int                      LEN      = 4,
    parameter int                      INPUTS   = 2,
    parameter int                      INPUTSB  = 1,
    parameter int                      OUTPUTS  = 2,
    parameter int                      OUTPUTSB = 1,
    parameter int                      DEPTHB   = 2,
    parameter int                      MAX_OUT  = 4,
    parameter logic [OUTPUTS*ADDR-1:0] MASKS    = '0,
    parameter logic [OUTPUTS*ADDR-1:0] BASES    = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [INPUTS-1:0]       in_ready,
    input  logic [INPUTS-1:0]       in_valid,
    input  logic [INPUTS*ADDR-1:0]  in_addr,
    input  logic [INPUTS*LEN-1:0]   in_len,
`ifdef DLSC_AXI_ROUTER_CMDQ_QOS_EN
    input  logic [INPUTS*4-1:0]     in_qos,
`endif
    input  logic [OUTPUTS-1:0]      out_ready,
    output logic [OUTPUTS-1:0]      out_valid,
    output logic [OUTPUTS*ADDR-1:0] out_addr,
    output logic [OUTPUTS*LEN-1:0]  out_len,
    input  logic [OUTPUTS-1:0]      out_done,
    input  logic [INPUTS-1:0]       cmd_full_input,
    input  logic [OUTPUTS-1:0]      cmd_full_output,
    output logic                    cmd_push,
    output logic                    cmd_error,
    output logic [INPUTS-1:0]       cmd_input_onehot,
    output logic [OUTPUTS-1:0]      cmd_output_onehot,
    output logic [INPUTSB-1:0]      cmd_input,
    output logic [OUTPUTSB-1:0]     cmd_output
);
    localparam int            DEPTH = 2**DEPTHB;
    localparam int            CNTW  = $clog2(MAX_OUT+1);
    localparam logic [CNTW:0] MAX_V = (CNTW+1)'(MAX_OUT);

    logic [INPUTS-1:0][ADDR-1:0]     head_addr_p0;
    logic [INPUTS-1:0][LEN-1:0]      head_len_p0;
    logic [INPUTS-1:0][OUTPUTSB-1:0] head_out_p0;
    logic [INPUTS-1:0]               head_err_p0;
    logic [INPUTS-1:0]               elig_p0;
    logic [OUTPUTS-1:0]              out_ok_p0;
    logic                            gnt_p0;
    logic [INPUTSB-1:0]              gnt_idx_p0;
    logic                            gnt_hit_p0;
    logic [OUTPUTSB-1:0]             gnt_out_p0;
    logic [ADDR-1:0]                 gnt_addr_p0;
    logic [LEN-1:0]                  gnt_len_p0;
    logic [INPUTSB-1:0]              rr_ptr;
`ifdef DLSC_AXI_ROUTER_CMDQ_QOS_EN
    logic [INPUTS-1:0][3:0]          head_qos_p0;
    logic [3:0]                      gnt_qos_p0;
`endif

    // ---- stage p0: input queues and head decode ----
    for (genvar i = 0; i < INPUTS; i++) begin : g_in
        logic [ADDR-1:0]     mem_addr [DEPTH];
        logic [LEN-1:0]      mem_len  [DEPTH];
        logic [DEPTHB:0]     wr_ptr, rd_ptr, fill;
        logic                wr_en, pop, hit;
        logic [OUTPUTSB-1:0] hit_idx;

        // fill never exceeds DEPTH, so its MSB alone marks full
        assign fill        = wr_ptr - rd_ptr;
        assign in_ready[i] = !fill[DEPTHB];
        assign wr_en       = in_valid[i] && in_ready[i];
        assign pop         = gnt_p0 && (gnt_idx_p0 == INPUTSB'(i));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + (DEPTHB+1)'(1);
                if (pop)   rd_ptr <= rd_ptr + (DEPTHB+1)'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem_addr[wr_ptr[DEPTHB-1:0]] <= in_addr[i*ADDR +: ADDR];
                mem_len[wr_ptr[DEPTHB-1:0]]  <= in_len[i*LEN +: LEN];
            end
        end

        assign head_addr_p0[i] = mem_addr[rd_ptr[DEPTHB-1:0]];
        assign head_len_p0[i]  = mem_len[rd_ptr[DEPTHB-1:0]];

`ifdef DLSC_AXI_ROUTER_CMDQ_QOS_EN
        logic [3:0] mem_qos [DEPTH];
        always_ff @(posedge clk) begin
            if (wr_en) mem_qos[wr_ptr[DEPTHB-1:0]] <= in_qos[i*4 +: 4];
        end
        assign head_qos_p0[i] = mem_qos[rd_ptr[DEPTHB-1:0]];
`endif

        // descending scan so the lowest matching output wins on overlap
        always_comb begin
            hit     = 1'b0;
            hit_idx = '0;
            for (int o = OUTPUTS-1; o >= 0; o--) begin
                if ((head_addr_p0[i] & MASKS[o*ADDR +: ADDR]) == BASES[o*ADDR +: ADDR]) begin
                    hit     = 1'b1;
                    hit_idx = OUTPUTSB'(o);
                end
            end
        end

        assign head_err_p0[i] = !hit;
        assign head_out_p0[i] = hit_idx;
        assign elig_p0[i]     = (fill != '0) && !cmd_full_input[i] && (!hit || out_ok_p0[hit_idx]);
    end

    always_comb begin
        int j;
        j          = 0;
        gnt_p0     = 1'b0;
        gnt_idx_p0 = rr_ptr;
`ifdef DLSC_AXI_ROUTER_CMDQ_QOS_EN
        gnt_qos_p0 = '0;
`endif
        for (int k = 1; k <= INPUTS; k++) begin
            j = (int'(rr_ptr) + k) % INPUTS;
`ifdef DLSC_AXI_ROUTER_CMDQ_QOS_EN
            // strictly-greater keeps the round-robin order among equal qos
            if (elig_p0[j] && (!gnt_p0 || head_qos_p0[j] > gnt_qos_p0)) begin
                gnt_qos_p0 = head_qos_p0[j];
`else
            if (elig_p0[j] && !gnt_p0) begin
`endif
                gnt_p0     = 1'b1;
                gnt_idx_p0 = INPUTSB'(j);
            end
        end
    end

    assign gnt_hit_p0  = gnt_p0 && !head_err_p0[gnt_idx_p0];
    assign gnt_out_p0  = head_out_p0[gnt_idx_p0];
    assign gnt_addr_p0 = head_addr_p0[gnt_idx_p0];
    assign gnt_len_p0  = head_len_p0[gnt_idx_p0];

    // ---- stage p1: registered command and output slots ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr            <= INPUTSB'(INPUTS-1);
            cmd_push          <= 1'b0;
            cmd_error         <= 1'b0;
            cmd_input         <= '0;
            cmd_input_onehot  <= '0;
            cmd_output        <= '0;
            cmd_output_onehot <= '0;
        end else begin
            cmd_push          <= gnt_p0;
            cmd_error         <= gnt_p0 && head_err_p0[gnt_idx_p0];
            cmd_input         <= gnt_p0 ? gnt_idx_p0 : '0;
            cmd_input_onehot  <= gnt_p0 ? (INPUTS'(1) << gnt_idx_p0) : '0;
            cmd_output        <= gnt_hit_p0 ? gnt_out_p0 : '0;
            cmd_output_onehot <= gnt_hit_p0 ? (OUTPUTS'(1) << gnt_out_p0) : '0;
            if (gnt_p0) rr_ptr <= gnt_idx_p0;
        end
    end

    for (genvar o = 0; o < OUTPUTS; o++) begin : g_out
        logic            vld_p1;
        logic [ADDR-1:0] addr_p1;
        logic [LEN-1:0]  len_p1;
        logic [CNTW-1:0] cnt;
        logic            load, acc, dec;

        assign load = gnt_hit_p0 && (gnt_out_p0 == OUTPUTSB'(o));
        assign acc  = vld_p1 && out_ready[o];
        assign dec  = out_done[o] && (cnt != '0);
        // the command being accepted this cycle already counts against the limit
        assign out_ok_p0[o] = !cmd_full_output[o] && (!vld_p1 || out_ready[o]) &&
                              (({1'b0, cnt} + (CNTW+1)'(acc)) < MAX_V);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_p1 <= 1'b0;
                cnt    <= '0;
            end else begin
                if (load)           vld_p1 <= 1'b1;
                else if (out_ready[o]) vld_p1 <= 1'b0;
                if (acc && !dec)      cnt <= cnt + CNTW'(1);
                else if (dec && !acc) cnt <= cnt - CNTW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (load) begin
                addr_p1 <= gnt_addr_p0 & MASKS[o*ADDR +: ADDR];
                len_p1  <= gnt_len_p0;
            end
        end

        assign out_valid[o]               = vld_p1;
        assign out_addr[o*ADDR +: ADDR]   = addr_p1;
        assign out_len[o*LEN +: LEN]      = len_p1;
    end

endmodule

// File: tb/tb_dlsc_axi_router_cmdq.sv
// Testbench for dlsc_axi_router_cmdq: directed scenarios plus random traffic against a
// queue-based reference model of the routing rules.
`timescale 1ns/1ps
module tb_dlsc_axi_router_cmdq;
    localparam logic [63:0] MASKS = {32'hFFFF_F000, 32'hFFFF_F000};
    localparam logic [63:0] BASES = {32'h0000_1000, 32'h0000_0000};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  in_ready, in_valid;
    logic [63:0] in_addr;
    logic [7:0]  in_len;
    logic [1:0]  out_ready, out_valid, out_done;
    logic [63:0] out_addr;
    logic [7:0]  out_len;
    logic [1:0]  cmd_full_input, cmd_full_output;
    logic        cmd_push, cmd_error;
    logic [1:0]  cmd_input_onehot, cmd_output_onehot;
    logic        cmd_input, cmd_output;

    dlsc_axi_router_cmdq #(
        .ADDR(32), .LEN(4), .INPUTS(2), .INPUTSB(1), .OUTPUTS(2), .OUTPUTSB(1),
        .DEPTHB(2), .MAX_OUT(4), .MASKS(MASKS), .BASES(BASES)
    ) dut (
        .clk(clk), .rst(rst),
        .in_ready(in_ready), .in_valid(in_valid), .in_addr(in_addr), .in_len(in_len),
        .out_ready(out_ready), .out_valid(out_valid), .out_addr(out_addr), .out_len(out_len),
        .out_done(out_done), .cmd_full_input(cmd_full_input), .cmd_full_output(cmd_full_output),
        .cmd_push(cmd_push), .cmd_error(cmd_error), .cmd_input_onehot(cmd_input_onehot),
        .cmd_output_onehot(cmd_output_onehot), .cmd_input(cmd_input), .cmd_output(cmd_output)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
    } ent_t;

    int tests = 0;
    int fails = 0;

    ent_t        mq [2][$];
    int          mcnt [2];
    bit          mov [2];
    logic [31:0] maddr [2];
    logic [3:0]  mlen [2];
    int          mptr;
    bit          epush, eerr;
    int          ein, eout;

    int acc1, npush, nin0, nin1, nerr;
    bit track_alt, have_prev;
    logic prev_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int route(input logic [31:0] a);
        if ((a & 32'hFFFF_F000) == 32'h0000_0000) return 0;
        if ((a & 32'hFFFF_F000) == 32'h0000_1000) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            mcnt[i] = 0;
            mov[i]  = 1'b0;
        end
        mptr  = 1;
        epush = 1'b0;
    endtask

    task automatic model_edge();
        bit   ok [2];
        bit   el [2];
        bit   wr [2];
        int   g, r;
        ent_t e;
        for (int o = 0; o < 2; o++)
            ok[o] = !cmd_full_output[o] && (!mov[o] || out_ready[o]) &&
                    (mcnt[o] + ((mov[o] && out_ready[o]) ? 1 : 0)) < 4;
        for (int i = 0; i < 2; i++) begin
            el[i] = 1'b0;
            wr[i] = in_valid[i] && (mq[i].size() < 4);
            if (mq[i].size() > 0 && !cmd_full_input[i]) begin
                r     = route(mq[i][0].addr);
                el[i] = (r < 0) || ok[r];
            end
        end
        g = -1;
        for (int k = 1; k <= 2; k++)
            if (g < 0 && el[(mptr + k) % 2]) g = (mptr + k) % 2;
        for (int o = 0; o < 2; o++) begin
            bit a, d;
            a = mov[o] && out_ready[o];
            d = out_done[o] && (mcnt[o] > 0);
            if (a && !d) mcnt[o]++;
            else if (d && !a) mcnt[o]--;
            if (out_ready[o]) mov[o] = 1'b0;
        end
        epush = (g >= 0);
        eerr  = 1'b0;
        ein   = 0;
        eout  = 0;
        if (g >= 0) begin
            e    = mq[g].pop_front();
            mptr = g;
            ein  = g;
            r    = route(e.addr);
            if (r < 0) eerr = 1'b1;
            else begin
                eout     = r;
                mov[r]   = 1'b1;
                maddr[r] = e.addr & 32'hFFFF_F000;
                mlen[r]  = e.len;
            end
        end
        for (int i = 0; i < 2; i++)
            if (wr[i]) mq[i].push_back({in_addr[i*32 +: 32], in_len[i*4 +: 4]});
    endtask

    task automatic check_all();
        logic [1:0] er, ev;
        er[0] = mq[0].size() < 4;
        er[1] = mq[1].size() < 4;
        ev    = {mov[1], mov[0]};
        chk("in_ready", in_ready, er);
        chk("out_valid", out_valid, ev);
        chk("cmd_push", cmd_push, epush);
        if (epush) begin
            chk("cmd_error", cmd_error, eerr);
            chk("cmd_input", cmd_input, 64'(ein));
            chk("cmd_input_onehot", cmd_input_onehot, 64'(1) << ein);
            if (eerr) begin
                chk("cmd_output_err", cmd_output, 0);
                chk("cmd_output_onehot_err", cmd_output_onehot, 0);
            end else begin
                chk("cmd_output", cmd_output, 64'(eout));
                chk("cmd_output_onehot", cmd_output_onehot, 64'(1) << eout);
            end
        end
        for (int o = 0; o < 2; o++) begin
            if (mov[o]) begin
                chk("out_addr", out_addr[o*32 +: 32], maddr[o]);
                chk("out_len", out_len[o*4 +: 4], mlen[o]);
            end
        end
    endtask

    task automatic tick();
        if (out_valid[1] && out_ready[1]) acc1++;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (cmd_push) begin
            npush++;
            if (cmd_error) nerr++;
            if (cmd_input) nin1++; else nin0++;
            if (track_alt) begin
                if (have_prev) chk("fair_alternate", cmd_input, !prev_in);
                prev_in   = cmd_input;
                have_prev = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid        = 2'b00;
        out_ready       = 2'b11;
        out_done        = 2'b11;
        cmd_full_input  = 2'b00;
        cmd_full_output = 2'b00;
        repeat (12) tick();
        out_done = 2'b00;
    endtask

    initial begin
        in_valid = '0; in_addr = '0; in_len = '0; out_ready = '0; out_done = '0;
        cmd_full_input = '0; cmd_full_output = '0;
        acc1 = 0; npush = 0; nin0 = 0; nin1 = 0; nerr = 0;
        track_alt = 1'b0; have_prev = 1'b0; prev_in = 1'b0;
        model_reset();

        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 2'b11);
        chk("rst_out_valid", out_valid, 2'b00);
        chk("rst_cmd_push", cmd_push, 0);
        chk("rst_cmd_error", cmd_error, 0);
        chk("rst_cmd_in_oh", cmd_input_onehot, 0);
        chk("rst_cmd_out_oh", cmd_output_onehot, 0);
        chk("rst_cmd_input", cmd_input, 0);
        chk("rst_cmd_output", cmd_output, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // single command to out1
        in_valid = 2'b01; in_addr[31:0] = 32'h0000_1000; in_len[3:0] = 4'd3;
        tick();
        in_valid = 2'b00;
        chk("single_push_early", cmd_push, 0);
        tick();
        chk("single_push", cmd_push, 1);
        chk("single_input", cmd_input, 0);
        chk("single_output", cmd_output, 1);
        chk("single_out_valid", out_valid, 2'b10);
        chk("single_out_addr", out_addr[63:32], 32'h0000_1000);
        chk("single_out_len", out_len[7:4], 4'd3);

        // fairness: both inputs saturate out0
        drain();
        in_valid = 2'b11; in_addr = {32'h0000_0200, 32'h0000_0100};
        out_ready = 2'b11; out_done = 2'b01;
        npush = 0; nin0 = 0; nin1 = 0; have_prev = 1'b0; track_alt = 1'b1;
        repeat (34) tick();
        track_alt = 1'b0;
        chk("fair_total", npush, 33);
        chk("fair_min_share", (nin0 < nin1) ? nin0 : nin1, 16);

        // outstanding limit on out1
        drain();
        acc1 = 0; npush = 0; out_ready = 2'b11; out_done = 2'b00;
        in_valid = 2'b11; in_addr = {32'h0000_1100, 32'h0000_1000};
        repeat (3) tick();
        in_valid = 2'b00;
        repeat (10) tick();
        chk("lim_accepted", acc1, 4);
        chk("lim_pushes", npush, 4);
        out_done = 2'b10; tick(); out_done = 2'b00;
        chk("lim_hold", cmd_push, 0);
        tick();
        chk("lim_fifth", cmd_push, 1);
        tick();
        out_done = 2'b10; tick(); out_done = 2'b00;
        tick();
        chk("lim_sixth", cmd_push, 1);
        out_done = 2'b10; tick(); out_done = 2'b00;
        acc1 = 0;
        in_valid = 2'b01; in_addr[31:0] = 32'h0000_1200;
        repeat (2) tick();
        in_valid = 2'b00;
        repeat (8) tick();
        chk("lim_same_edge", acc1, 1);

        // decode miss followed by a normal command
        drain();
        nerr = 0;
        in_valid = 2'b01; in_addr[31:0] = 32'h0000_F000;
        tick();
        in_addr[31:0] = 32'h0000_0040;
        tick();
        in_valid = 2'b00;
        chk("miss_error", cmd_error, 1);
        chk("miss_out_oh", cmd_output_onehot, 0);
        chk("miss_no_valid", out_valid, 2'b00);
        tick();
        chk("miss_next_error", cmd_error, 0);
        chk("miss_next_valid", out_valid, 2'b01);
        chk("miss_count", nerr, 1);

        // backpressure skip and queue fill
        drain();
        cmd_full_output = 2'b01; in_valid = 2'b11; in_addr = {32'h0000_1010, 32'h0000_0010};
        tick();
        in_valid = 2'b00;
        tick();
        chk("bp_push", cmd_push, 1);
        chk("bp_input1", cmd_input, 1);
        tick();
        chk("bp_hold", cmd_push, 0);
        cmd_full_output = 2'b00;
        tick();
        chk("bp_release_push", cmd_push, 1);
        chk("bp_release_input0", cmd_input, 0);
        cmd_full_input = 2'b11; in_valid = 2'b01; in_addr[31:0] = 32'h0000_0020;
        repeat (3) tick();
        chk("fill_ready3", in_ready[0], 1);
        tick();
        chk("fill_ready4", in_ready[0], 0);
        in_valid = 2'b00;

        // asynchronous reset with queued work
        drain();
        out_ready = 2'b00; in_valid = 2'b11; in_addr = {32'h0000_0300, 32'h0000_0200};
        tick();
        tick();
        in_valid = 2'b00;
        chk("arst_pre_push", cmd_push, 1);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 2'b00);
        chk("arst_cmd_push", cmd_push, 0);
        chk("arst_in_ready", in_ready, 2'b11);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 2'b11;
        tick();
        in_valid = 2'b11;
        tick();
        in_valid = 2'b00;
        tick();
        chk("arst_first_push", cmd_push, 1);
        chk("arst_first_input", cmd_input, 0);

        // random traffic
        drain();
        repeat (500) begin
            for (int i = 0; i < 2; i++) begin
                int sel;
                sel = $urandom_range(0, 2);
                in_valid[i] = 1'($urandom_range(0, 1));
                in_addr[i*32 +: 32] = ((sel == 0) ? 32'h0 : (sel == 1) ? 32'h1000 : 32'hF000) |
                                      32'($urandom_range(0, 4095));
                in_len[i*4 +: 4] = 4'($urandom);
                cmd_full_input[i] = ($urandom_range(0, 6) == 0);
            end
            for (int o = 0; o < 2; o++) begin
                out_ready[o]       = ($urandom_range(0, 3) != 0);
                out_done[o]        = ($urandom_range(0, 4) == 0);
                cmd_full_output[o] = ($urandom_range(0, 6) == 0);
            end
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
